// File: rtl/ad_wave_capture.sv
// Triggered single-shot capture of DEPTH ADC samples with frame max/min; trigger sample is written in its own cycle, rd_data lags rd_addr by 1 cycle.
// No backpressure: each sample_en is consumed or dropped in the cycle it arrives, and arm is ignored while busy.
module ad_wave_capture #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          sample_en,
  input  logic [7:0]    ad_data,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic          auto_mode,
  input  logic          arm,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          done_pulse,
  output logic          trig_forced,
  output logic [7:0]    max_val,
  output logic [7:0]    min_val
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_addr, wr_ptr;
  logic [7:0]      prev, acc_max, acc_min, max_nxt, min_nxt;
  logic            prev_valid;
  logic [TW-1:0]   to_cnt, to_cnt_inc;
  logic            crossing, timeout_hit, trig_fire, wr_en, frame_end, arm_take;

  always_comb begin
    to_cnt_inc  = (to_cnt == {TW{1'b1}}) ? to_cnt : to_cnt + TW'(1);
    crossing    = 1'b0;
    if (prev_valid) begin
      if (trig_edge) crossing = (prev > trig_level) && (ad_data <= trig_level);
      else           crossing = (prev < trig_level) && (ad_data >= trig_level);
    end
    timeout_hit = auto_mode && (to_cnt_inc >= TW'(TIMEOUT));
    max_nxt     = (ad_data > acc_max) ? ad_data : acc_max;
    min_nxt     = (ad_data < acc_min) ? ad_data : acc_min;
  end

  always_comb begin
    state_nxt = state;
    arm_take  = 1'b0;
    trig_fire = 1'b0;
    wr_en     = 1'b0;
    frame_end = 1'b0;
    wr_ptr    = wr_addr;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          arm_take  = 1'b1;
          state_nxt = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (sample_en && (crossing || timeout_hit)) begin
          trig_fire = 1'b1;
          wr_en     = 1'b1;
          wr_ptr    = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_en) begin
          wr_en = 1'b1;
          if (wr_addr == AW'(DEPTH - 1)) begin
            frame_end = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      to_cnt      <= '0;
      acc_max     <= '0;
      acc_min     <= '0;
      max_val     <= '0;
      min_val     <= '0;
      trig_forced <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_pulse <= frame_end;
      if (arm_take) begin
        prev_valid  <= 1'b0;
        to_cnt      <= '0;
        trig_forced <= 1'b0;
      end
      if (state == WAIT_TRIG && sample_en) begin
        prev       <= ad_data;
        prev_valid <= 1'b1;
        to_cnt     <= to_cnt_inc;
      end
      // A genuine crossing wins over a timeout landing on the same sample.
      if (trig_fire) begin
        acc_max     <= ad_data;
        acc_min     <= ad_data;
        wr_addr     <= AW'(1);
        trig_forced <= !crossing;
      end else if (state == CAPTURE && sample_en) begin
        acc_max <= max_nxt;
        acc_min <= min_nxt;
        wr_addr <= wr_addr + AW'(1);
      end
      if (frame_end) begin
        max_val <= max_nxt;
        min_val <= min_nxt;
      end
    end
  end

  // Frame RAM: no reset so it maps onto block RAM; read-before-write on collision.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= ad_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= '0;
    else            rd_data <= mem[rd_addr];
  end

  assign busy = (state == WAIT_TRIG) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ad_wave_capture.sv
// Directed bench for ad_wave_capture: DEPTH=256, TIMEOUT=16, random sample gaps of 0-5 cycles.
module tb_ad_wave_capture;

  localparam int DEPTH = 256;
  localparam int AW = 8;
  localparam int TIMEOUT = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [7:0]    ad_data = '0;
  logic [7:0]    trig_level = '0;
  logic          trig_edge = 1'b0;
  logic          auto_mode = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy, done, done_pulse, trig_forced;
  logic [7:0]    max_val, min_val;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int fr [DEPTH];

  ad_wave_capture #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_en(sample_en), .ad_data(ad_data),
    .trig_level(trig_level), .trig_edge(trig_edge), .auto_mode(auto_mode), .arm(arm),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .done_pulse(done_pulse),
    .trig_forced(trig_forced), .max_val(max_val), .min_val(min_val)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (done_pulse) pulse_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int d);
    repeat ($urandom_range(0, 5)) tick();
    sample_en = 1'b1;
    ad_data   = 8'(d);
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input int a, output int v);
    rd_addr = AW'(a);
    tick();
    v = int'(rd_data);
  endtask

  task automatic frame_minmax(output int mx, output int mn);
    mx = 0;
    mn = 255;
    for (int i = 0; i < DEPTH; i++) begin
      if (fr[i] > mx) mx = fr[i];
      if (fr[i] < mn) mn = fr[i];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_pulse"}, done_pulse, 0);
    check({tag, "_trig_forced"}, trig_forced, 0);
    check({tag, "_max"}, max_val, 0);
    check({tag, "_min"}, min_val, 0);
  endtask

  initial begin
    int n, v, mx, mn;

    // reset state
    repeat (3) tick();
    check_reset_vals("rst");
    sys_rst_n = 1'b1;
    tick();
    check("rst_idle_busy", busy, 0);

    // rising edge, level 128, ramp 0,1,2,... ; arm mid-capture is ignored
    trig_level = 8'd128; trig_edge = 1'b0; auto_mode = 1'b0;
    do_arm();
    check("r_arm_busy", busy, 1);
    n = -1;
    for (int i = 0; i < 600; i++) begin
      send(i);
      n = i;
      if (i == 200) begin
        do_arm();
        check("r_arm_in_capture_busy", busy, 1);
      end
      if (done) break;
    end
    check("r_last_sample_idx", n, 383);
    check("r_done_pulse", done_pulse, 1);
    check("r_busy_after", busy, 0);
    check("r_trig_forced", trig_forced, 0);
    check("r_max", max_val, 255);
    check("r_min", min_val, 0);
    tick();
    check("r_pulse_drop", done_pulse, 0);
    check("r_pulse_count", pulse_cnt, 1);
    rd(0, v);   check("r_rd0", v, 128);
    rd(1, v);   check("r_rd1", v, 129);
    rd(255, v); check("r_rd255", v, 127);

    // falling edge, level 100, 200,150,100,50,...; arm from DONE holds old max/min
    trig_level = 8'd100; trig_edge = 1'b1;
    do_arm();
    check("f_done_drop", done, 0);
    check("f_busy", busy, 1);
    check("f_max_held", max_val, 255);
    check("f_min_held", min_val, 0);
    n = -1;
    for (int k = 0; k < 700; k++) begin
      v = (200 - 50 * k) & 255;
      send(v);
      n = k;
      if (k >= 2 && k - 2 < DEPTH) fr[k-2] = v;
      if (k == 100) check("f_max_held_mid", max_val, 255);
      if (done) break;
    end
    check("f_last_sample_idx", n, 257);
    frame_minmax(mx, mn);
    check("f_max", max_val, mx);
    check("f_min", min_val, mn);
    rd(0, v);   check("f_rd0", v, 100);
    rd(1, v);   check("f_rd1", v, 50);
    rd(255, v); check("f_rd255", v, fr[255]);

    // arm together with a sample (ignored), first sample above level never triggers
    trig_level = 8'd128; trig_edge = 1'b0;
    arm = 1'b1; sample_en = 1'b1; ad_data = 8'd10;
    tick();
    arm = 1'b0; sample_en = 1'b0;
    check("a_busy", busy, 1);
    send(200);
    send(210);
    send(50);
    check("a_still_busy", busy, 1);
    check("a_not_done", done, 0);
    send(130);
    fr[0] = 130;
    for (int k = 1; k < DEPTH; k++) begin
      fr[k] = (k * 7) & 255;
      send(fr[k]);
      if (k == DEPTH - 2) check("a_not_done_early", done, 0);
    end
    check("a_done", done, 1);
    frame_minmax(mx, mn);
    check("a_max", max_val, mx);
    check("a_min", min_val, mn);
    rd(0, v);  check("a_rd0", v, 130);
    rd(37, v); check("a_rd37", v, fr[37]);

    // auto mode: forced trigger on sample TIMEOUT
    auto_mode = 1'b1;
    do_arm();
    for (int k = 1; k <= TIMEOUT + DEPTH - 1; k++) begin
      send(50);
      if (k == TIMEOUT - 1) check("t_no_force_early", trig_forced, 0);
      if (k == TIMEOUT + DEPTH - 2) check("t_not_done_early", done, 0);
    end
    check("t_done", done, 1);
    check("t_trig_forced", trig_forced, 1);
    check("t_max", max_val, 50);
    check("t_min", min_val, 50);
    rd(0, v); check("t_rd0", v, 50);

    // auto_mode off: waits indefinitely
    auto_mode = 1'b0;
    do_arm();
    check("w_forced_cleared", trig_forced, 0);
    repeat (40) send(50);
    check("w_busy", busy, 1);
    check("w_not_done", done, 0);

    // reset at write 100 of a frame
    send(0);
    send(128);
    for (int k = 1; k < 100; k++) send(1);
    sample_en = 1'b1; ad_data = 8'd77;
    #2 sys_rst_n = 1'b0;
    #1 check_reset_vals("mr");
    sample_en = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    check_reset_vals("mr_rel");
    send(0);
    send(200);
    check("mr_idle_ignores", busy, 0);
    do_arm();
    send(120);
    for (int k = 0; k < DEPTH; k++) begin
      fr[k] = (140 + 3 * k) & 255;
      send(fr[k]);
    end
    check("n_done", done, 1);
    check("n_trig_forced", trig_forced, 0);
    frame_minmax(mx, mn);
    check("n_max", max_val, mx);
    check("n_min", min_val, mn);
    rd(0, v);   check("n_rd0", v, 140);
    rd(99, v);  check("n_rd99", v, fr[99]);
    rd(100, v); check("n_rd100", v, 184);
    rd(255, v); check("n_rd255", v, fr[255]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
